// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit that owns the HI/LO
// registers of the MIPS core.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start_i, op_i       - issue MULT(00)/MULTU(01)/DIV(10)/DIVU(11)
//   rs_i, rt_i          - multiplicand/dividend, multiplier/divisor
//   mthi_i, mtlo_i      - write wdata_i to HI / LO (IDLE only, start has priority)
//   wdata_i             - MTHI/MTLO data
//   mf_req_i            - pipeline reads HI/LO this cycle
//   hi_o, lo_o          - architectural HI/LO
//   busy_o              - operation in flight
//   done_o              - one-cycle pulse after HI/LO were written by a mul/div
//   stall_o             - combinational stall request to the pipeline
//
// Every operation takes WIDTH+1 cycles: WIDTH RUN iterations plus one FIXUP
// cycle that applies the sign correction and writes HI/LO.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             mf_req_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
      return ~v + PW'(1);
   endfunction

   // Operand magnitudes: only MULT/DIV interpret operands as signed.
   logic signed [WIDTH-1:0] rs_s, rt_s;
   logic                    signed_op, rs_neg, rt_neg;
   logic [WIDTH-1:0]        rs_mag, rt_mag;

   assign rs_s      = rs_i;
   assign rt_s      = rt_i;
   assign signed_op = ~op_i[0];
   assign rs_neg    = signed_op & (rs_s < 0);
   assign rt_neg    = signed_op & (rt_s < 0);
   assign rs_mag    = rs_neg ? neg_w(rs_i) : rs_i;
   assign rt_mag    = rt_neg ? neg_w(rt_i) : rt_i;

   // Iteration datapath. mcand holds the multiplicand or divisor magnitude.
   logic             is_div, res_neg, rem_neg, div_zero;
   logic [WIDTH-1:0] dvd_raw, mcand, rem, quo;
   logic [PW-1:0]    prod;
   logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;

   assign mul_sum  = {1'b0, prod[PW-1:WIDTH]}
                   + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
   // The restored remainder is always below the divisor, so a borrow out of
   // this (WIDTH+1)-bit subtraction means "does not go".
   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mcand};

   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign prod_fix = res_neg ? neg_p(prod) : prod;
   assign quo_fix  = res_neg ? neg_w(quo) : quo;
   assign rem_fix  = rem_neg ? neg_w(rem) : rem;

   assign stall_o = ~reset & busy_o & (start_i | mf_req_i | mthi_i | mtlo_i);

   // Datapath registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (state == IDLE && start_i) begin
         is_div   <= op_i[1];
         res_neg  <= rs_neg ^ rt_neg;
         rem_neg  <= rs_neg;
         div_zero <= (rt_i == '0);
         dvd_raw  <= rs_i;
         mcand    <= rt_mag;
         prod     <= {{WIDTH{1'b0}}, rs_mag};
         rem      <= '0;
         quo      <= rs_mag;
      end else if (state == RUN) begin
         if (is_div) begin
            rem <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
         end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
         end
      end
   end

   // Control FSM and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_o   <= '0;
         lo_o   <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= RUN;
                  cnt    <= '0;
                  busy_o <= 1'b1;
               end else begin
                  if (mthi_i) hi_o <= wdata_i;
                  if (mtlo_i) lo_o <= wdata_i;
               end
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
            end
            FIXUP: begin
               if (!is_div) begin
                  hi_o <= prod_fix[PW-1:WIDTH];
                  lo_o <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi_o <= dvd_raw;
                  lo_o <= '1;
               end else begin
                  hi_o <= rem_fix;
                  lo_o <= quo_fix;
               end
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: a driver issues directed and random operations
// and pushes the expected HI/LO plus the expected done cycle into a
// scoreboard; a monitor on the falling edge checks done/busy/stall/HI/LO.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start_i, mthi_i, mtlo_i, mf_req_i;
   logic [1:0]   op_i;
   logic [W-1:0] rs_i, rt_i, wdata_i, hi_o, lo_o;
   logic         busy_o, done_o, stall_o;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
      .rs_i(rs_i), .rt_i(rt_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
      .wdata_i(wdata_i), .mf_req_i(mf_req_i), .hi_o(hi_o), .lo_o(lo_o),
      .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           dcyc;
   } exp_t;

   exp_t         scb[$];
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           errors = 0, checks = 0;
   bit           checking = 1'b0;
   bit           exp_done, exp_busy, exp_stall;

   task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic exp_t ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t            e;
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, up;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      e.dcyc = 0;
      case (op)
         2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
         default: begin
            if (b == '0) begin
               e.hi = a;
               e.lo = '1;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               e.hi = r[31:0]; e.lo = q[31:0];
            end else begin
               up = ua / ub; e.lo = up[31:0];
               up = ua % ub; e.hi = up[31:0];
            end
         end
      endcase
      return e;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (checking) begin
         exp_done = (scb.size() > 0) && (cyc == scb[0].dcyc);
         check_b("done_o", done_o, exp_done);
         if (exp_done) begin
            m_hi = scb[0].hi;
            m_lo = scb[0].lo;
            void'(scb.pop_front());
         end
         exp_busy  = (scb.size() > 0) && (cyc < scb[0].dcyc);
         exp_stall = !reset && exp_busy && (start_i || mf_req_i || mthi_i || mtlo_i);
         check_b("busy_o", busy_o, exp_busy);
         check_b("stall_o", stall_o, exp_stall);
         check_w("hi_o", hi_o, m_hi);
         check_w("lo_o", lo_o, m_lo);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_busy();
      return (scb.size() > 0) && (cyc < scb[0].dcyc);
   endfunction

   task automatic wait_idle();
      int g = 0;
      while (model_busy()) begin
         tick();
         g++;
         if (g > 200) begin
            errors++; checks++;
            $display("FAIL wait_idle: timeout after %0d cycles", g);
            break;
         end
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit with_mt, input bit with_mf);
      exp_t e;
      start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
      mthi_i = with_mt; mtlo_i = with_mt; wdata_i = 32'h5A5A_1234; mf_req_i = with_mf;
      wait_idle();
      tick();
      e = ref_op(op, a, b);
      e.dcyc = cyc + W + 1;
      scb.push_back(e);
      start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; mf_req_i = 1'b0;
   endtask

   task automatic mt(input bit hi_en, input bit lo_en, input logic [W-1:0] d);
      mthi_i = hi_en; mtlo_i = lo_en; wdata_i = d;
      wait_idle();
      tick();
      if (hi_en) m_hi = d;
      if (lo_en) m_lo = d;
      mthi_i = 1'b0; mtlo_i = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (scb.size() > 0) begin
         tick();
         g++;
         if (g > 200) begin
            errors++; checks++;
            $display("FAIL drain: timeout, %0d results outstanding", scb.size());
            break;
         end
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      scb.delete();
      m_hi = '0;
      m_lo = '0;
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; mf_req_i = 1'b0;
      op_i = 2'b00; rs_i = '0; rt_i = '0; wdata_i = '0;
      tick();
      checking = 1'b1;
      tick();
      reset = 1'b0;

      issue(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);          drain();
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);  drain();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);          drain();
      issue(2'b11, 32'd100, 32'd7, 0, 0);                drain();
      issue(2'b11, 32'h0000_1234, 32'd0, 0, 0);          drain();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);  drain();
      issue(2'b10, 32'hFFFF_EDCC, 32'd0, 0, 0);          drain();
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);          drain();

      // MTLO then MULTU 3x4 with MF reads stalled during the operation
      mt(0, 1, 32'h0000_00AA);
      issue(2'b01, 32'd3, 32'd4, 0, 0);
      mf_req_i = 1'b1;
      repeat (10) tick();
      mf_req_i = 1'b0;
      drain();

      // MTHI and MTLO together; start plus MT in the same cycle drops MT
      mt(1, 1, 32'hCAFE_F00D);
      issue(2'b00, 32'd6, 32'hFFFF_FFF9, 1, 0);          drain();

      // Back-to-back: second start held (stalled) until the done cycle,
      // then an MT request held across the second operation
      issue(2'b01, 32'd12345, 32'd678, 0, 0);
      issue(2'b11, 32'hDEAD_BEEF, 32'd3, 0, 1);
      mt(1, 0, 32'h1111_2222);
      drain();

      // Reset in the middle of a DIV abandons it
      issue(2'b10, 32'd1000, 32'd3, 0, 0);
      repeat (9) tick();
      do_reset();
      repeat (40) tick();

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick(),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 2) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         if ($urandom_range(0, 1) == 0) drain();
      end
      drain();

      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
